// File: rtl/fpu_addsub_stage.sv
// fpu_addsub_stage: registered FP32 add/subtract stage for the FPU execution unit.
// Resolves the dynamic rounding mode and handles NaN, infinity and signed-zero
// operands around the add/sub datapath. Registers the result and flags, and keeps a
// sticky fflags accumulator.
// Configuration macro FPU_ADDSUB_OUTREG_EN adds an operand register stage (S1)
// ahead of the output register, for a latency of 2 instead of 1.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   in_valid_i/in_ready_o  operand handshake (rs1_i, rs2_i, sub_i, rm_i, frm_i)
//   flush_i                kill all in-flight beats
//   out_valid_o/out_ready_i result handshake (result_o, fflags_o = {NV,DZ,OF,UF,NX})
//   fflags_clr_i           clear sticky accumulator fflags_acc_o
module fpu_addsub_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] rs1_i,
    input  logic [31:0] rs2_i,
    input  logic        sub_i,
    input  logic [2:0]  rm_i,
    input  logic [2:0]  frm_i,
    input  logic        flush_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] result_o,
    output logic [4:0]  fflags_o,
    input  logic        fflags_clr_i,
    output logic [4:0]  fflags_acc_o
);
    localparam int unsigned FW = 5;
    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [2:0]  RM_RTZ = 3'b001;
    localparam logic [2:0]  RM_RDN = 3'b010;
    localparam logic [2:0]  RM_RUP = 3'b011;
    localparam logic [2:0]  RM_DYN = 3'b111;

    // {exponent (subnormals read as 1), 24-bit significand with hidden bit}
    function automatic logic [31:0] unpack(input logic [30:0] x);
        return {((x[30:23] == 8'd0) ? 8'd1 : x[30:23]), (x[30:23] != 8'd0), x[22:0]};
    endfunction

    // Finite add/sub with rounding; b carries its effective sign.
    function automatic logic [36:0] fp_datapath(input logic [31:0] a, input logic [31:0] b,
                                                input logic [2:0] rm);
        logic        a_ge, s_l, nx, up, ovf, uf, max_mag;
        logic [7:0]  e_l, e_s, diff;
        logic [23:0] m_l, m_s;
        logic [4:0]  d;
        logic [49:0] m_s_al;
        logic [50:0] sum;
        logic [5:0]  lz, sh;
        logic [51:0] n;
        logic [8:0]  e_res;
        logic [30:0] rnd;
        logic [36:0] r;
        a_ge = a[30:0] >= b[30:0];
        s_l  = a_ge ? a[31] : b[31];
        {e_l, m_l} = a_ge ? unpack(a[30:0]) : unpack(b[30:0]);
        {e_s, m_s} = a_ge ? unpack(b[30:0]) : unpack(a[30:0]);
        diff = e_l - e_s;
        // Beyond 26 places the small operand only affects sticky; clamping keeps that.
        d      = (diff > 8'd26) ? 5'd26 : diff[4:0];
        m_s_al = {m_s, 26'b0} >> d;
        sum = (a[31] ^ b[31]) ? ({1'b0, m_l, 26'b0} - {1'b0, m_s_al})
                              : ({1'b0, m_l, 26'b0} + {1'b0, m_s_al});
        lz = 6'd51;
        for (int i = 0; i < 51; i++) begin
            if (sum[i]) lz = 6'(50 - i);
        end
        // Stop normalising at the minimum exponent so tiny results become subnormal.
        sh    = ({2'b0, lz} > e_l) ? e_l[5:0] : lz;
        n     = {sum, 1'b0} << sh;
        e_res = {1'b0, e_l} + 9'd1 - {3'b0, sh};
        nx    = n[27] | (|n[26:0]);
        case (rm)
            3'b000:  up = n[27] & ((|n[26:0]) | n[28]);
            3'b010:  up = nx & s_l;
            3'b011:  up = nx & ~s_l;
            3'b100:  up = n[27];
            default: up = 1'b0;
        endcase
        // Rounding carry ripples from mantissa into exponent (subnormal->normal, ->inf).
        rnd = {(n[51] ? e_res[7:0] : 8'd0), n[50:28]} + 31'(up);
        ovf = (e_res >= 9'd255) || (rnd[30:23] == 8'hFF);
        uf  = nx & (rnd[30:23] == 8'h00) & ~ovf;
        max_mag = (rm == RM_RTZ) || ((rm == RM_RDN) && !s_l) || ((rm == RM_RUP) && s_l);
        if (sum == 51'd0)
            r = {(rm == RM_RDN), 31'd0, 5'b00000};
        else if (ovf)
            r = {s_l, (max_mag ? 31'h7F7F_FFFF : 31'h7F80_0000), 5'b00101};
        else
            r = {s_l, rnd, 3'b000, uf, nx};
        return r;
    endfunction

    // Special-operand resolution in priority order, then the datapath.
    function automatic logic [36:0] fp_eval(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] rm);
        logic a_nan, b_nan, a_snan, b_snan, a_inf, b_inf;
        logic [36:0] r;
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_snan = a_nan && !a[22];
        b_snan = b_nan && !b[22];
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (rm >= 3'd5)                           r = {QNAN, 5'b10000};
        else if (a_snan || b_snan)                r = {QNAN, 5'b10000};
        else if (a_nan || b_nan)                  r = {QNAN, 5'b00000};
        else if (a_inf && b_inf && (a[31] != b[31])) r = {QNAN, 5'b10000};
        else if (a_inf)                           r = {a, 5'b00000};
        else if (b_inf)                           r = {b, 5'b00000};
        else if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0))
            r = {((rm == RM_RDN) ? (a[31] | b[31]) : (a[31] & b[31])), 31'd0, 5'b00000};
        else                                      r = fp_datapath(a, b, rm);
        return r;
    endfunction

    logic [2:0]    rm_eff_c;
    logic [31:0]   rs2_eff_c;
    logic [36:0]   eval_c;
    logic          stage_valid_c;
    logic          down_ready_c;
    logic          handshake_c;
    logic          out_valid_q;
    logic [31:0]   result_q;
    logic [FW-1:0] fflags_q;
    logic [FW-1:0] acc_q;

    assign rm_eff_c     = (rm_i == RM_DYN) ? frm_i : rm_i;
    assign rs2_eff_c    = {rs2_i[31] ^ sub_i, rs2_i[30:0]};
    assign down_ready_c = !out_valid_q || out_ready_i;
    assign handshake_c  = out_valid_q && out_ready_i;

`ifdef FPU_ADDSUB_OUTREG_EN
    logic        s1_valid_q;
    logic [31:0] s1_a_q, s1_b_q;
    logic [2:0]  s1_rm_q;
    logic        s1_ready_c;

    assign s1_ready_c    = !s1_valid_q || down_ready_c;
    assign in_ready_o    = s1_ready_c && !flush_i;
    assign eval_c        = fp_eval(s1_a_q, s1_b_q, s1_rm_q);
    assign stage_valid_c = s1_valid_q;

    // S1: operands with effective sign and rounding mode
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_rm_q    <= '0;
        end else if (flush_i) begin
            s1_valid_q <= 1'b0;
        end else if (s1_ready_c) begin
            s1_valid_q <= in_valid_i;
            if (in_valid_i) begin
                s1_a_q  <= rs1_i;
                s1_b_q  <= rs2_eff_c;
                s1_rm_q <= rm_eff_c;
            end
        end
    end
`else
    assign in_ready_o    = down_ready_c && !flush_i;
    assign eval_c        = fp_eval(rs1_i, rs2_eff_c, rm_eff_c);
    assign stage_valid_c = in_valid_i;
`endif

    // Output register: loads only when empty or draining, so data holds under stall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            fflags_q    <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (down_ready_c) begin
            out_valid_q <= stage_valid_c;
            if (stage_valid_c) begin
                result_q <= eval_c[36:5];
                fflags_q <= eval_c[4:0];
            end
        end
    end

    // Sticky accumulator; a clear coinciding with a delivery keeps that beat's flags
    always_ff @(posedge clk_i) begin
        if (rst_i)             acc_q <= '0;
        else if (fflags_clr_i) acc_q <= handshake_c ? fflags_q : '0;
        else if (handshake_c)  acc_q <= acc_q | fflags_q;
    end

    assign out_valid_o  = out_valid_q;
    assign result_o     = result_q;
    assign fflags_o     = fflags_q;
    assign fflags_acc_o = acc_q;
endmodule

// File: tb/tb_fpu_addsub_stage.sv
// Self-checking bench for fpu_addsub_stage: expected results are queued when a beat
// is accepted and compared in order as results are delivered.
module tb_fpu_addsub_stage;
`ifdef FPU_ADDSUB_OUTREG_EN
    localparam int LAT = 2;
    localparam logic [31:0] HELD = 32'h4000_0000;
`else
    localparam int LAT = 1;
    localparam logic [31:0] HELD = 32'h4080_0000;
`endif
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, DYN = 3'd7;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, sub, flush, out_valid, out_ready, fflags_clr;
    logic [31:0] rs1, rs2, result;
    logic [2:0]  rm, frm;
    logic [4:0]  fflags, fflags_acc;

    int total = 0;
    int bad   = 0;
    logic [36:0] sb[$];
    logic [36:0] mon_e;
    logic [31:0] exp_res;
    logic [4:0]  exp_flg;

    fpu_addsub_stage dut (
        .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .rs1_i(rs1), .rs2_i(rs2), .sub_i(sub), .rm_i(rm), .frm_i(frm), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .result_o(result),
        .fflags_o(fflags), .fflags_clr_i(fflags_clr), .fflags_acc_o(fflags_acc)
    );

    always #5 clk = ~clk;

    // Scoreboard: compare deliveries, record accepts, drop killed beats on flush
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                total++;
                if (sb.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_output got=%h/%h", result, fflags);
                end else begin
                    mon_e = sb.pop_front();
                    if (result !== mon_e[36:5] || fflags !== mon_e[4:0]) begin
                        bad++;
                        $display("FAIL sb_result got=%h/%h want=%h/%h",
                                 result, fflags, mon_e[36:5], mon_e[4:0]);
                    end
                end
            end
            if (in_valid && in_ready) sb.push_back({exp_res, exp_flg});
            if (flush) sb.delete();
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [2:0] r, input logic [2:0] f,
                        input logic [31:0] er, input logic [4:0] ef);
        int n = 0;
        rs1 = a; rs2 = b; sub = s; rm = r; frm = f;
        exp_res = er; exp_flg = ef; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (!in_ready) begin
            bad++;
            $display("FAIL send_timeout in_ready=%b want=1", in_ready);
        end
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        while (sb.size() != 0 && n < 200) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", sb.size());
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total += 5;
        if (in_ready !== 1'b1)    begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_out_valid got=%b want=0", out_valid); end
        if (result !== 32'd0)     begin bad++; $display("FAIL rst_result got=%h want=0", result); end
        if (fflags !== 5'd0)      begin bad++; $display("FAIL rst_fflags got=%h want=0", fflags); end
        if (fflags_acc !== 5'd0)  begin bad++; $display("FAIL rst_acc got=%h want=0", fflags_acc); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1;
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, RNE, 3'd0, 32'h4040_0000, 5'h00);
        in_valid = 1'b0;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            total++;
            if (out_valid !== (k == LAT)) begin
                bad++;
                $display("FAIL latency cycle=%0d out_valid=%b want=%b", k, out_valid, k == LAT);
            end
        end
        wait_drain();
    endtask

    task automatic test_special();
        @(posedge clk); #1;
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        send(32'h7F80_0000, 32'h7F80_0000, 1'b1, RNE, 3'd0, 32'h7FC0_0000, 5'h10);
        send(32'h7F80_0001, 32'h3F80_0000, 1'b0, RNE, 3'd0, 32'h7FC0_0000, 5'h10);
        send(32'h7FC0_0001, 32'h3F80_0000, 1'b0, RNE, 3'd0, 32'h7FC0_0000, 5'h00);
        send(32'hFF80_0000, 32'h3F80_0000, 1'b0, RNE, 3'd0, 32'hFF80_0000, 5'h00);
        send(32'h3F80_0000, 32'h7F80_0000, 1'b1, RNE, 3'd0, 32'hFF80_0000, 5'h00);
        wait_drain();
        total++;
        if (fflags_acc !== 5'h10) begin bad++; $display("FAIL acc_special got=%h want=10", fflags_acc); end
    endtask

    task automatic test_rm();
        @(posedge clk); #1;
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, DYN, 3'd0, 32'h7F80_0000, 5'h05);
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, DYN, 3'd5, 32'h7FC0_0000, 5'h10);
        send(32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, RTZ, 3'd0, 32'h7F7F_FFFF, 5'h05);
        send(32'h3F80_0000, 32'h4000_0000, 1'b0, 3'd6, 3'd0, 32'h7FC0_0000, 5'h10);
        wait_drain();
        total++;
        if (fflags_acc !== 5'h15) begin bad++; $display("FAIL acc_rm got=%h want=15", fflags_acc); end
    endtask

    task automatic test_zero();
        @(posedge clk); #1;
        send(32'h0000_0000, 32'h0000_0000, 1'b1, RNE, 3'd0, 32'h0000_0000, 5'h00);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, RDN, 3'd0, 32'h8000_0000, 5'h00);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, RNE, 3'd0, 32'h8000_0000, 5'h00);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1, RNE, 3'd0, 32'h0000_0000, 5'h00);
        send(32'h3F80_0000, 32'h3F80_0000, 1'b1, RDN, 3'd0, 32'h8000_0000, 5'h00);
        wait_drain();
    endtask

    task automatic test_datapath();
        @(posedge clk); #1;
        send(32'h3F80_0000, 32'h3F00_0000, 1'b1, RNE, 3'd0, 32'h3F00_0000, 5'h00);
        send(32'h3F80_0000, 32'h3380_0000, 1'b0, RNE, 3'd0, 32'h3F80_0000, 5'h01);
        send(32'h3F80_0000, 32'h3380_0000, 1'b0, RUP, 3'd0, 32'h3F80_0001, 5'h01);
        send(32'h0000_0001, 32'h0000_0001, 1'b0, RNE, 3'd0, 32'h0000_0002, 5'h00);
        send(32'h0080_0000, 32'h0000_0001, 1'b1, RNE, 3'd0, 32'h007F_FFFF, 5'h00);
        send(32'hBFC0_0000, 32'h3E80_0000, 1'b0, RNE, 3'd0, 32'hBFA0_0000, 5'h00);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        @(posedge clk); #1;
        out_ready = 1'b1;
        fork
            begin
                send(32'h3F80_0000, 32'h3F80_0000, 1'b0, RNE, 3'd0, 32'h4000_0000, 5'h00);
                send(32'h4000_0000, 32'h4000_0000, 1'b0, RNE, 3'd0, 32'h4080_0000, 5'h00);
                send(32'h3F80_0000, 32'h4000_0000, 1'b0, RNE, 3'd0, 32'h4040_0000, 5'h00);
                send(32'h4080_0000, 32'h4080_0000, 1'b0, RNE, 3'd0, 32'h4100_0000, 5'h00);
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                @(posedge clk); #1;
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    total += 3;
                    if (in_ready !== 1'b0)  begin bad++; $display("FAIL stall_in_ready got=%b want=0", in_ready); end
                    if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b want=1", out_valid); end
                    if (result !== HELD)    begin bad++; $display("FAIL stall_result got=%h want=%h", result, HELD); end
                end
                @(posedge clk); #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_flush();
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0, RNE, 3'd0, 32'h4000_0000, 5'h00);
`ifdef FPU_ADDSUB_OUTREG_EN
        send(32'h4000_0000, 32'h4000_0000, 1'b0, RNE, 3'd0, 32'h4080_0000, 5'h00);
`endif
        // Output beat is delivered in the flush cycle; a new beat is offered and refused
        rs1 = 32'h4080_0000; rs2 = 32'h4080_0000; exp_res = 32'h4100_0000; exp_flg = 5'h00;
        in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
        end
        wait_drain();
    endtask

    task automatic test_clr();
        int n = 0;
        @(posedge clk); #1;
        @(negedge clk);
        total++;
        if (fflags_acc !== 5'h15) begin bad++; $display("FAIL acc_before_clr got=%h want=15", fflags_acc); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(32'h3F80_0000, 32'h3380_0000, 1'b0, RNE, 3'd0, 32'h3F80_0000, 5'h01);
        in_valid = 1'b0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL clr_wait out_valid=%b want=1", out_valid); end
        @(posedge clk); #1;
        fflags_clr = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        @(negedge clk);
        total++;
        if (fflags_acc !== 5'h01) begin bad++; $display("FAIL acc_clr_hs got=%h want=01", fflags_acc); end
        @(posedge clk); #1;
        fflags_clr = 1'b1;
        @(posedge clk); #1;
        fflags_clr = 1'b0;
        @(negedge clk);
        total++;
        if (fflags_acc !== 5'h00) begin bad++; $display("FAIL acc_clr_only got=%h want=00", fflags_acc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; sub = 1'b0; flush = 1'b0; out_ready = 1'b1;
        fflags_clr = 1'b0; rs1 = '0; rs2 = '0; rm = '0; frm = '0;
        exp_res = '0; exp_flg = '0;
        test_reset();
        test_basic();
        test_special();
        test_rm();
        test_zero();
        test_datapath();
        test_back_to_back();
        test_flush();
        test_clr();
        wait_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
